// File: rtl/vq18_mes_loop_pkg.sv
// Shared types and arithmetic for the VQ18 mismatch-shaping loop.
package vq18_pkg;
  localparam int N_ELEM  = 18;
  localparam int STATE_W = 8;
  localparam int ADDR_W  = 5;

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} fsm_t;

  // s + k - 18*sel, evaluated in 11 bits and clamped to the state range
  function automatic logic signed [STATE_W-1:0] sat_upd(
    input logic signed [STATE_W-1:0] s,
    input logic        [ADDR_W-1:0]  k,
    input logic                      sel
  );
    logic signed [10:0] sum;
    sum = $signed({{(11-STATE_W){s[STATE_W-1]}}, s}) + $signed({6'd0, k})
          - (sel ? 11'sd18 : 11'sd0);
    if (sum > 11'sd127)       return 8'sd127;
    else if (sum < -11'sd128) return -8'sd128;
    else                      return sum[STATE_W-1:0];
  endfunction
endpackage

// File: rtl/vq18_mes_loop_if.sv
// Code handshake, state export, sorter return and element-enable bus.
interface vq18_mes_loop_if #(
  parameter int N  = 18,
  parameter int DW = 8,
  parameter int AW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      code_in;
  logic [N*DW-1:0] st_out;
  logic [N*AW-1:0] rank_in;
  logic [N-1:0]    sel;
  logic            out_valid;

  modport master (output in_valid, code_in, rank_in,
                  input  in_ready, st_out, sel, out_valid);
  modport slave  (input  in_valid, code_in, rank_in,
                  output in_ready, st_out, sel, out_valid);
endinterface

// File: rtl/vq18_mes_loop_elem_state.sv
// One unit element's usage state with saturating first-order update.
module vq18_elem_state
  import vq18_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      sel,
  input  logic [ADDR_W-1:0]         k_eff,
  output logic signed [STATE_W-1:0] st
);
  always_ff @(posedge clk) begin
    if (!rst_n)  st <= '0;
    else if (en) st <= sat_upd(st, k_eff, sel);
  end
endmodule

// File: rtl/vq18_mes_loop.sv
// VQ18 mismatch-shaping loop: FSM, sorter wait, rank-to-sel decode, state array.
module vq18_mes_loop
  import vq18_pkg::*;
#(
  parameter int N        = 18,
  parameter int DW       = 8,
  parameter int AW       = 5,
  parameter int SORT_LAT = 4
)(
  input  logic             clk,
  input  logic             rst_n,
  vq18_mes_loop_if.slave   bus
);
  fsm_t              state, state_nxt;
  logic [7:0]        cnt;
  logic [4:0]        k_eff;
  logic [N-1:0]      sel_q, sel_nxt;
  logic              out_valid_q;
  logic              commit;
  logic [AW-1:0]     addr;
  logic [N-1:0][DW-1:0] st_arr;

  assign commit        = (state == COMMIT);
  assign bus.in_ready  = (state == IDLE);
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.st_out    = st_arr;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A zero-latency sorter needs no wait; the commit cycle alone covers it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = (SORT_LAT == 0) ? COMMIT : WAIT;
      WAIT:    if (cnt == 8'(SORT_LAT - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      k_eff       <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= commit;
      if (state == IDLE && bus.in_valid) begin
        k_eff <= (bus.code_in > 5'(N)) ? 5'(N) : bus.code_in;
        cnt   <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
      if (commit) sel_q <= sel_nxt;
    end
  end

  // Top-k ranked addresses; out-of-range addresses are dropped
  always_comb begin
    sel_nxt = '0;
    addr    = '0;
    for (int r = 0; r < N; r++) begin
      addr = bus.rank_in[r*AW +: AW];
      if (5'(r) < k_eff && int'(addr) < N) sel_nxt[addr] = 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_elem
    vq18_elem_state u_elem (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (commit),
      .sel   (sel_nxt[i]),
      .k_eff (k_eff),
      .st    (st_arr[i])
    );
  end
endmodule

// File: tb/tb_vq18_mes_loop.sv
// Bench for vq18_mes_loop: 4-cycle behavioural sorter, directed table, reference model.
module tb_vq18_mes_loop;
  localparam int N = 18;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vq18_mes_loop_if #(.N(N), .DW(8), .AW(5)) bus ();
  vq18_mes_loop #(.N(N), .DW(8), .AW(5), .SORT_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int m_st[N];

  // Descending order, ties to the lower address
  function automatic void sort_desc(input int s[N], output int ord[N]);
    bit used[N];
    for (int i = 0; i < N; i++) used[i] = 1'b0;
    for (int r = 0; r < N; r++) begin
      int best = -1;
      for (int i = 0; i < N; i++)
        if (!used[i] && (best < 0 || s[i] > s[best])) best = i;
      ord[r] = best;
      used[best] = 1'b1;
    end
  endfunction

  function automatic int st_i(input int i);
    return int'($signed(bus.st_out[i*8 +: 8]));
  endfunction

  logic [N*5-1:0] rpipe [LAT];
  always @(posedge clk) begin
    int s[N];
    int ord[N];
    logic [N*5-1:0] rk;
    for (int i = 0; i < N; i++) s[i] = st_i(i);
    sort_desc(s, ord);
    for (int r = 0; r < N; r++) rk[r*5 +: 5] = 5'(ord[r]);
    rpipe[0] <= rk;
    for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign bus.rank_in = rpipe[LAT-1];

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [143:0] model_packed();
    logic [143:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*8 +: 8] = 8'(m_st[i]);
    return p;
  endfunction

  task automatic model_code(input int c, output logic [N-1:0] es, output int ke);
    int ord[N];
    ke = (c > N) ? N : c;
    sort_desc(m_st, ord);
    es = '0;
    for (int r = 0; r < ke; r++) es[ord[r]] = 1'b1;
    for (int i = 0; i < N; i++) begin
      int v;
      v = m_st[i] + ke - (es[i] ? N : 0);
      m_st[i] = (v > 127) ? 127 : (v < -128) ? -128 : v;
    end
  endtask

  task automatic do_code(input logic [4:0] c, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 50) begin @(negedge clk); g++; end
    bus.in_valid = 1'b1;
    bus.code_in  = c;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = n; break; end
    end
  endtask

  typedef struct {
    logic [4:0]   code;
    logic [N-1:0] sel;
    int           s0;
    int           s17;
  } vec_t;

  initial begin
    vec_t vt[5];
    logic [N-1:0] es;
    int ke, lat, ovc, sum, sat;
    logic [N-1:0] sel_seen;

    vt[0] = '{5'd9,  18'h001FF, -9, 9};
    vt[1] = '{5'd9,  18'h3FE00,  0, 0};
    vt[2] = '{5'd0,  18'h00000,  0, 0};
    vt[3] = '{5'd18, 18'h3FFFF,  0, 0};
    vt[4] = '{5'd25, 18'h3FFFF,  0, 0};

    bus.in_valid = 1'b0;
    bus.code_in  = '0;
    for (int i = 0; i < N; i++) m_st[i] = 0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 144'(bus.sel), 144'(0));
    chk("rst_ov", 144'(bus.out_valid), 144'(0));
    chk("rst_rdy", 144'(bus.in_ready), 144'(1));
    chk("rst_st", bus.st_out, 144'(0));
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      do_code(vt[v].code, lat);
      model_code(int'(vt[v].code), es, ke);
      chk("vec_lat", 144'(lat), 144'(LAT + 1));
      chk("vec_sel", 144'(bus.sel), 144'(vt[v].sel));
      chk("vec_s0", 144'(st_i(0)), 144'(vt[v].s0));
      chk("vec_s17", 144'(st_i(17)), 144'(vt[v].s17));
      chk("vec_st", bus.st_out, model_packed());
      chk("vec_rdy", 144'(bus.in_ready), 144'(1));
    end

    // Busy input: second code offered during WAIT must be dropped
    @(negedge clk);
    bus.in_valid = 1'b1; bus.code_in = 5'd9;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.in_valid = 1'b1; bus.code_in = 5'd3;
    @(negedge clk); bus.in_valid = 1'b0;
    ovc = 0; sel_seen = '0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin ovc++; sel_seen = bus.sel; end
    end
    model_code(9, es, ke);
    chk("busy_ovcnt", 144'(ovc), 144'(1));
    chk("busy_sel", 144'(sel_seen), 144'(18'h001FF));
    chk("busy_st", bus.st_out, model_packed());

    // Reset while waiting on the sorter
    @(negedge clk);
    bus.in_valid = 1'b1; bus.code_in = 5'd9;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_rdy", 144'(bus.in_ready), 144'(1));
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < N; i++) m_st[i] = 0;
    ovc = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid) ovc++;
    end
    chk("mrst_ovcnt", 144'(ovc), 144'(0));
    chk("mrst_st", bus.st_out, 144'(0));
    chk("mrst_sel", 144'(bus.sel), 144'(0));

    for (int t = 0; t < 1000; t++) begin
      int c;
      c = int'($urandom_range(0, 18));
      do_code(5'(c), lat);
      model_code(c, es, ke);
      sum = 0; sat = 0;
      for (int i = 0; i < N; i++) begin
        sum += st_i(i);
        if (st_i(i) >= 127 || st_i(i) <= -128) sat++;
      end
      chk("rnd_lat", 144'(lat), 144'(LAT + 1));
      chk("rnd_sel", 144'(bus.sel), 144'(es));
      chk("rnd_pop", 144'($countones(bus.sel)), 144'(ke));
      chk("rnd_sum", 144'(sum), 144'(0));
      chk("rnd_sat", 144'(sat), 144'(0));
      chk("rnd_st", bus.st_out, model_packed());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
